// File: rtl/sram_like_resp_pkg.sv
// Shared definitions for the sram-like responder: access-size encodings,
// parameter bounds and width helpers.
package sram_like_resp_pkg;

  typedef enum logic [1:0] {
    SRAM_SIZE_BYTE = 2'd0,
    SRAM_SIZE_HALF = 2'd1,
    SRAM_SIZE_WORD = 2'd2
  } sram_size_e;

  localparam int unsigned RESP_LAT_MAX   = 8;
  localparam int unsigned RESP_OUTST_MAX = 16;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index 0..n-1.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_like_resp_if.sv
// sram-like request/response bus between an initiator (master) and the
// responder (slave).
interface sram_like_resp_if;
  import sram_like_resp_pkg::*;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_resp_fifo.sv
// Synchronous FIFO with modulo-DEPTH pointers; push and pop in the same
// cycle are legal even when full.
module sram_resp_fifo
  import sram_like_resp_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned W     = 32,
  localparam int unsigned PW    = ptr_width(DEPTH),
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(i_push && o_full && !i_pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(i_pop && o_empty));

endmodule

// File: rtl/sram_like_resp.sv
// Responder end of the sram-like bus: accepts requests onto a synchronous RAM
// and returns one in-order data_ok per request after LATENCY cycles.
module sram_like_resp
  import sram_like_resp_pkg::*;
#(
  parameter int unsigned RAM_AW    = 12,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              reset,
  sram_like_resp_if.slave   bus,
  input  logic              addr_stall,
  input  logic              resp_stall,
  output logic              ram_en,
  output logic [STRB_W-1:0] ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int unsigned CW = cnt_width(MAX_OUTST);

  logic              w_hs;
  logic [CW-1:0]     r_outst;
  logic [LATENCY-1:0] r_pv;
  logic              r_pw0;
  logic              w_push;
  logic [DATA_W-1:0] w_push_data;
  logic              w_dok;
  logic              w_f_push;
  logic              w_f_pop;
  logic              w_f_empty;
  logic              w_f_full;
  logic [DATA_W-1:0] w_f_rdata;
  logic [CW-1:0]     w_f_count;
  logic              w_unused;

  // Request side: accept while under the outstanding limit.
  assign w_hs        = ~reset & bus.req & ~addr_stall & (r_outst < CW'(MAX_OUTST));
  assign bus.addr_ok = w_hs;
  assign ram_en      = w_hs;
  assign ram_we      = (w_hs && bus.wr) ? bus.wstrb : '0;
  assign ram_addr    = bus.addr[RAM_AW+1:2];
  assign ram_wdata   = bus.wdata;
  assign w_unused    = ^{bus.size, bus.addr[1:0], bus.addr[ADDR_W-1:RAM_AW+2]};

  // Valid/wr shift unconditionally; only stage 0 needs wr to mask write data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pv  <= '0;
      r_pw0 <= 1'b0;
    end else begin
      r_pv[0] <= w_hs;
      r_pw0   <= bus.wr;
      for (int k = 1; k < int'(LATENCY); k++) r_pv[k] <= r_pv[k-1];
    end
  end

  assign w_push = r_pv[LATENCY-1];

  if (LATENCY == 1) begin : g_lat1
    assign w_push_data = r_pw0 ? '0 : ram_rdata;
  end else begin : g_latn
    logic [DATA_W-1:0] r_pd [1:LATENCY-1];

    always_ff @(posedge clk) begin
      r_pd[1] <= r_pw0 ? '0 : ram_rdata;
      for (int k = 2; k < int'(LATENCY); k++) r_pd[k] <= r_pd[k-1];
    end

    assign w_push_data = r_pd[LATENCY-1];
  end

  // An empty FIFO is bypassed so the first response appears in the push cycle.
  assign w_dok       = (~w_f_empty | w_push) & ~resp_stall & ~reset;
  assign bus.data_ok = w_dok;
  assign bus.rdata   = w_dok ? (w_f_empty ? w_push_data : w_f_rdata) : '0;
  assign w_f_pop     = w_dok & ~w_f_empty;
  assign w_f_push    = w_push & ~(w_f_empty & w_dok);

  sram_resp_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_f_push),
    .i_wdata (w_push_data),
    .i_pop   (w_f_pop),
    .o_rdata (w_f_rdata),
    .o_full  (w_f_full),
    .o_empty (w_f_empty),
    .o_count (w_f_count)
  );

  // Requests accepted but not yet answered (pipeline plus FIFO).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outst <= '0;
    end else if (w_hs && !w_dok) begin
      r_outst <= r_outst + CW'(1);
    end else if (!w_hs && w_dok) begin
      r_outst <= r_outst - CW'(1);
    end
  end

  a_lat_range: assert property (@(posedge clk)
    (LATENCY >= 1) && (LATENCY <= RESP_LAT_MAX));
  a_outst_range: assert property (@(posedge clk)
    (MAX_OUTST >= 1) && (MAX_OUTST <= RESP_OUTST_MAX));
  a_fifo_bounded: assert property (@(posedge clk) disable iff (reset)
    (w_f_count <= r_outst) && !(w_f_push && w_f_full && !w_f_pop));

endmodule

// File: tb/tb_sram_like_resp.sv
// Directed bench for sram_like_resp with a queue-based response model and a
// behavioural RAM.
`timescale 1ns/1ps
module tb_sram_like_resp;
  import sram_like_resp_pkg::*;

  localparam int unsigned RAM_AW = 12;
  localparam int unsigned LAT    = 2;
  localparam int unsigned MAXO   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              addr_stall;
  logic              resp_stall;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              pl_en;
  logic [RAM_AW-1:0] pl_addr;
  logic [31:0]       pl_data;

  sram_like_resp_if bus_if ();

  sram_like_resp #(.RAM_AW(RAM_AW), .LATENCY(LAT), .MAX_OUTST(MAXO)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .addr_stall (addr_stall),
    .resp_stall (resp_stall),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM, 1-cycle read latency; preload port wins.
  logic [31:0] ram_mem [4096];
  always @(posedge clk) begin
    if (pl_en) begin
      ram_mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= ram_mem[ram_addr];
    end
  end

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] obs_q[$];
  logic [31:0] model_mem [4096];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_dok    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pre_val(input int i);
    return (i == 0) ? 32'h02800c0c : (32'hc0de0000 + 32'(i));
  endfunction

  // Model: each accepted request is answered in order, no earlier than LAT
  // cycles after acceptance, whenever resp_stall is low.
  always @(negedge clk) begin
    logic              exp_aok;
    logic              exp_dok;
    logic [31:0]       nd;
    logic [RAM_AW-1:0] w;
    if (pl_en) model_mem[pl_addr] = pl_data;
    if (reset) begin
      q.delete();
      chk("rst_addr_ok", 32'(bus_if.addr_ok), 32'd0);
      chk("rst_data_ok", 32'(bus_if.data_ok), 32'd0);
      chk("rst_rdata",   bus_if.rdata,        32'd0);
      chk("rst_ram_en",  32'(ram_en),         32'd0);
      chk("rst_ram_we",  32'(ram_we),         32'd0);
    end else begin
      exp_aok = bus_if.req && !addr_stall && (q.size() < int'(MAXO));
      chk("addr_ok",   32'(bus_if.addr_ok), 32'(exp_aok));
      chk("ram_en",    32'(ram_en),         32'(exp_aok));
      chk("ram_we",    32'(ram_we), (exp_aok && bus_if.wr) ? 32'(bus_if.wstrb) : 32'd0);
      chk("outst_cnt", 32'(dut.r_outst),    32'(q.size()));
      if (exp_aok) begin
        chk("ram_addr",  32'(ram_addr), 32'(bus_if.addr[RAM_AW+1:2]));
        chk("ram_wdata", ram_wdata,     bus_if.wdata);
      end
      exp_dok = !resp_stall && (q.size() > 0) && (q[0].due <= cyc);
      chk("data_ok", 32'(bus_if.data_ok), 32'(exp_dok));
      chk("rdata",   bus_if.rdata, exp_dok ? q[0].data : 32'd0);
      if (bus_if.data_ok) begin
        n_dok++;
        obs_q.push_back(bus_if.rdata);
      end
      if (exp_dok) void'(q.pop_front());
      if (exp_aok) begin
        w = bus_if.addr[RAM_AW+1:2];
        if (bus_if.wr) begin
          for (int b = 0; b < 4; b++)
            if (bus_if.wstrb[b]) model_mem[w][8*b +: 8] = bus_if.wdata[8*b +: 8];
          nd = 32'd0;
        end else begin
          nd = model_mem[w];
        end
        q.push_back('{due: cyc + int'(LAT), data: nd});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.req   = 1'b0;
    bus_if.wr    = 1'b0;
    bus_if.size  = 2'd2;
    bus_if.addr  = 32'd0;
    bus_if.wstrb = 4'd0;
    bus_if.wdata = 32'd0;
  endtask

  // Hold a request until accepted, then drop req on the next cycle.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    int t;
    t = 0;
    bus_if.req   = 1'b1;
    bus_if.wr    = w;
    bus_if.size  = 2'd2;
    bus_if.addr  = a;
    bus_if.wstrb = s;
    bus_if.wdata = d;
    #2;
    while (!bus_if.addr_ok && t < 20) begin
      tick();
      #2;
      t++;
    end
    chk("issue_accept", 32'(bus_if.addr_ok), 32'd1);
    tick();
    idle();
  endtask

  task automatic drain(input int bound);
    int t;
    t = 0;
    while (q.size() > 0 && t < bound) begin
      tick();
      t++;
    end
    chk("drain_done", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int nhs;
    int d0;
    logic [31:0] a;
    reset      = 1'b1;
    addr_stall = 1'b0;
    resp_stall = 1'b0;
    pl_en      = 1'b0;
    pl_addr    = '0;
    pl_data    = '0;
    idle();
    bus_if.req   = 1'b1;
    bus_if.wr    = 1'b1;
    bus_if.wstrb = 4'hf;
    #2;
    chk("t0_rst_addr_ok", 32'(bus_if.addr_ok), 32'd0);
    chk("t0_rst_data_ok", 32'(bus_if.data_ok), 32'd0);
    chk("t0_rst_ram_en",  32'(ram_en),         32'd0);
    chk("t0_rst_ram_we",  32'(ram_we),         32'd0);
    idle();
    tick();
    for (int i = 0; i < 6; i++) begin
      pl_en   = 1'b1;
      pl_addr = RAM_AW'(i);
      pl_data = pre_val(i);
      tick();
    end
    pl_en = 1'b0;
    reset = 1'b0;
    tick();
    tick();

    // Single read, LATENCY = 2.
    bus_if.req  = 1'b1;
    bus_if.addr = 32'h1c000000;
    #2;
    chk("t1_addr_ok_c0", 32'(bus_if.addr_ok), 32'd1);
    tick();
    idle();
    #2;
    chk("t1_data_ok_c1", 32'(bus_if.data_ok), 32'd0);
    tick();
    #2;
    chk("t1_data_ok_c2", 32'(bus_if.data_ok), 32'd1);
    chk("t1_rdata_c2",   bus_if.rdata,        32'h02800c0c);
    tick();
    #2;
    chk("t1_data_ok_c3", 32'(bus_if.data_ok), 32'd0);
    tick();

    // Six back-to-back reads.
    d0 = n_dok;
    for (int i = 0; i < 6; i++) issue(1'b0, 32'(4 * i), 4'h0, 32'd0);
    drain(30);
    chk("t2_resp_count", 32'(n_dok - d0), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("t2_order", obs_q[obs_q.size() - 6 + i], pre_val(i));

    // Outstanding limit under resp_stall.
    d0 = n_dok;
    resp_stall = 1'b1;
    nhs = 0;
    a = 32'd0;
    bus_if.req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus_if.addr = a;
      #2;
      if (bus_if.addr_ok) begin
        nhs++;
        a = a + 32'd4;
      end
      tick();
    end
    bus_if.addr = a;
    #2;
    chk("t3_hs_count",        32'(nhs),            32'd4);
    chk("t3_addr_ok_blocked", 32'(bus_if.addr_ok), 32'd0);
    resp_stall = 1'b0;
    nhs = 0;
    while (!bus_if.addr_ok && nhs < 10) begin
      tick();
      #2;
      nhs++;
    end
    chk("t3_fifth_accept", 32'(bus_if.addr_ok), 32'd1);
    tick();
    idle();
    drain(30);
    tick();
    chk("t3_outst_zero",  32'(dut.r_outst),   32'd0);
    chk("t3_resp_count",  32'(n_dok - d0),    32'd5);
    for (int i = 0; i < 5; i++)
      chk("t3_order", obs_q[obs_q.size() - 5 + i], pre_val(i));

    // Partial write then read-after-write.
    issue(1'b1, 32'h8, 4'hf,    32'haaaaaaaa);
    issue(1'b1, 32'h8, 4'b0101, 32'h11223344);
    issue(1'b0, 32'h8, 4'h0,    32'd0);
    drain(30);
    chk("t4_wr_rdata", obs_q[obs_q.size() - 2], 32'd0);
    chk("t4_rd_rdata", obs_q[obs_q.size() - 1], 32'haa22aa44);

    // Asynchronous reset with three reads in flight.
    resp_stall = 1'b1;
    for (int i = 1; i < 4; i++) issue(1'b0, 32'(4 * i), 4'h0, 32'd0);
    resp_stall = 1'b0;
    #1;
    chk("t5_data_ok_before", 32'(bus_if.data_ok), 32'd1);
    bus_if.req  = 1'b1;
    bus_if.addr = 32'h14;
    #1;
    reset = 1'b1;
    #1;
    chk("t5_data_ok_drop", 32'(bus_if.data_ok), 32'd0);
    chk("t5_addr_ok_drop", 32'(bus_if.addr_ok), 32'd0);
    chk("t5_ram_en_drop",  32'(ram_en),         32'd0);
    tick();
    tick();
    #2;
    idle();
    reset = 1'b0;
    d0 = n_dok;
    repeat (8) tick();
    chk("t5_no_stale",   32'(n_dok - d0),    32'd0);
    chk("t5_outst_zero", 32'(dut.r_outst),   32'd0);

    // addr_stall for the first three request cycles.
    addr_stall   = 1'b1;
    bus_if.req   = 1'b1;
    bus_if.addr  = 32'h14;
    nhs = 0;
    for (int c = 0; c < 5; c++) begin
      #2;
      if (c < 3) begin
        chk("t6_stall_addr_ok", 32'(bus_if.addr_ok), 32'd0);
        chk("t6_stall_ram_en",  32'(ram_en),         32'd0);
      end
      if (c == 3) chk("t6_hs_c3", 32'(bus_if.addr_ok), 32'd1);
      if (bus_if.addr_ok) nhs++;
      tick();
      if (c == 2) addr_stall = 1'b0;
      if (nhs > 0) idle();
    end
    chk("t6_hs_count", 32'(nhs), 32'd1);
    #2;
    chk("t6_data_ok", 32'(bus_if.data_ok), 32'd1);
    chk("t6_rdata",   bus_if.rdata,        pre_val(5));
    tick();
    #2;
    chk("t6_data_ok_after", 32'(bus_if.data_ok), 32'd0);
    tick();
    drain(20);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
